// File: rtl/regsel_pipe.sv
// Register-select pipeline stage: decodes rs1/rs2/rd from a LEGv8 instruction word,
// registers them behind valid/ready, and stalls on RAW hazards against in-flight writers.

module regsel_match #(
    parameter int SEL_W = 5
) (
    input  logic             we,
    input  logic [SEL_W-1:0] rd,
    input  logic [SEL_W-1:0] rs1,
    input  logic [SEL_W-1:0] rs2,
    input  logic             rs1_live,
    input  logic             rs2_live,
    output logic             hit
);
    assign hit = we && ((rs1_live && rd == rs1) || (rs2_live && rd == rs2));
endmodule

module regsel_pipe #(
    parameter int          SEL_W     = 5,
    parameter int          DEPTH     = 4,
    parameter logic [10:0] MOVK_OPC  = 11'b11110010100,
    parameter int          ZERO_REG  = 31,
    parameter bit          HAZARD_EN = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                instr,
    input  logic                       reg2loc,
    input  logic                       reg_write,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [SEL_W-1:0]           rs1,
    output logic [SEL_W-1:0]           rs2,
    output logic [SEL_W-1:0]           rd,
    output logic                       rd_we,
    input  logic                       retire,
    output logic [$clog2(DEPTH+1)-1:0] pend_count,
    output logic                       hazard
);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH-1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [SEL_W-1:0] ZR       = SEL_W'(ZERO_REG);

    logic [SEL_W-1:0] rs1_n, rs2_n, rd_n;
    logic             we_n, movk, accept, pop;
    logic             unused_bits;

    logic [DEPTH-1:0]            ent_we;
    logic [DEPTH-1:0][SEL_W-1:0] ent_rd;
    logic [DEPTH-1:0]            hit;
    logic [PTR_W-1:0]            head, tail;
    logic [CNT_W-1:0]            count;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign movk        = instr[31:21] == MOVK_OPC;
    assign rs1_n       = movk ? instr[SEL_W-1:0] : instr[5 +: SEL_W];
    assign rs2_n       = reg2loc ? instr[SEL_W-1:0] : instr[16 +: SEL_W];
    assign rd_n        = instr[SEL_W-1:0];
    assign we_n        = reg_write && rd_n != ZR;
    assign unused_bits = ^instr;

    // One comparator per scoreboard slot; popped slots have we cleared so they never match.
    for (genvar i = 0; i < DEPTH; i++) begin : g_match
        regsel_match #(.SEL_W(SEL_W)) u_match (
            .we       (ent_we[i]),
            .rd       (ent_rd[i]),
            .rs1      (rs1_n),
            .rs2      (rs2_n),
            .rs1_live (rs1_n != ZR),
            .rs2_live (rs2_n != ZR),
            .hit      (hit[i])
        );
    end

    assign hazard     = HAZARD_EN && in_valid && (|hit);
    assign in_ready   = (!out_valid || out_ready) && !hazard && (count < CNT_FULL);
    assign accept     = in_valid && in_ready;
    assign pop        = retire && (count != '0);
    assign pend_count = count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            rs1       <= '0;
            rs2       <= '0;
            rd        <= '0;
            rd_we     <= 1'b0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            ent_we    <= '0;
            ent_rd    <= '0;
        end else begin
            if (accept) begin
                out_valid    <= 1'b1;
                rs1          <= rs1_n;
                rs2          <= rs2_n;
                rd           <= rd_n;
                rd_we        <= we_n;
                ent_we[tail] <= we_n;
                ent_rd[tail] <= rd_n;
                tail         <= ptr_inc(tail);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            // head==tail with both active is impossible: pop needs count>0, push needs count<DEPTH
            if (pop) begin
                ent_we[head] <= 1'b0;
                head         <= ptr_inc(head);
            end
            if (accept && !pop)
                count <= count + 1'b1;
            else if (pop && !accept)
                count <= count - 1'b1;
        end
    end
endmodule

// File: tb/tb_regsel_pipe.sv
// Scoreboard bench for regsel_pipe: a queue-based reference model predicts handshake,
// hazard and occupancy; a monitor checks every presented output against expected selects.

module tb_regsel_pipe;
    localparam int          SEL_W = 5;
    localparam int          DEPTH = 4;
    localparam int          CNT_W = $clog2(DEPTH+1);
    localparam logic [10:0] MOVK  = 11'b11110010100;
    localparam logic [10:0] ADDOP = 11'b10001011000;
    localparam logic [10:0] SUBOP = 11'b11001011000;
    localparam logic [10:0] STUR  = 11'b11111000000;

    logic             clk, rst;
    logic             in_valid, in_ready, reg2loc, reg_write;
    logic [31:0]      instr;
    logic             out_valid, out_ready, rd_we, retire, hazard;
    logic [SEL_W-1:0] rs1, rs2, rd;
    logic [CNT_W-1:0] pend_count;

    regsel_pipe #(.SEL_W(SEL_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .reg2loc(reg2loc), .reg_write(reg_write), .out_valid(out_valid), .out_ready(out_ready),
        .rs1(rs1), .rs2(rs2), .rd(rd), .rd_we(rd_we), .retire(retire),
        .pend_count(pend_count), .hazard(hazard)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       we;
    } sel_t;

    sel_t exp_q[$];
    sel_t pend_q[$];
    bit   m_ov;
    int   n_vec, n_err;

    function automatic sel_t decode(input logic [31:0] i, input logic r2l, input logic rw);
        sel_t s;
        s.rs1 = (i[31:21] == MOVK) ? i[4:0] : i[9:5];
        s.rs2 = r2l ? i[4:0] : i[20:16];
        s.rd  = i[4:0];
        s.we  = rw && (i[4:0] != 5'd31);
        return s;
    endfunction

    function automatic bit blocked(input sel_t s);
        foreach (pend_q[k])
            if (pend_q[k].we && ((s.rs1 != 5'd31 && pend_q[k].rd == s.rs1) ||
                                 (s.rs2 != 5'd31 && pend_q[k].rd == s.rs2)))
                return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic cycle(input logic iv, input logic [31:0] ins, input logic r2l,
                         input logic rw, input logic ordy, input logic ret);
        sel_t s;
        bit   hz, rdy;
        @(negedge clk);
        in_valid = iv; instr = ins; reg2loc = r2l; reg_write = rw; out_ready = ordy; retire = ret;
        #1;
        s   = decode(ins, r2l, rw);
        hz  = iv && blocked(s);
        rdy = (!m_ov || ordy) && !hz && (pend_q.size() < DEPTH);
        check("hazard", 32'(hazard), 32'(hz));
        check("in_ready", 32'(in_ready), 32'(rdy));
        check("pend_count", 32'(pend_count), 32'(pend_q.size()));
        check("out_valid", 32'(out_valid), 32'(m_ov));
        @(posedge clk);
        if (ret && pend_q.size() > 0) void'(pend_q.pop_front());
        if (iv && rdy) begin
            pend_q.push_back(s);
            exp_q.push_back(s);
            m_ov = 1'b1;
        end else if (m_ov && ordy) begin
            m_ov = 1'b0;
        end
    endtask

    function automatic logic [4:0] rreg();
        return ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
    endfunction

    task automatic rand_cycles(input int n);
        logic [31:0] ins;
        for (int c = 0; c < n; c++) begin
            ins = $urandom;
            if ($urandom_range(0, 7) == 0) ins[31:21] = MOVK;
            ins[4:0] = rreg(); ins[9:5] = rreg(); ins[20:16] = rreg();
            cycle($urandom_range(0, 9) < 7, ins, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 3);
        end
    endtask

    task automatic drain();
        repeat (DEPTH + 2) cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    // Output monitor: every presented output must match the oldest expected entry.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst && out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_output: got rs1=%0d rs2=%0d rd=%0d we=%0b expected none",
                             rs1, rs2, rd, rd_we);
                end else begin
                    check("selects", 32'({rs1, rs2, rd, rd_we}), 32'(exp_q[0]));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        n_vec = 0; n_err = 0; m_ov = 1'b0;
        rst = 1'b0; in_valid = 1'b0; instr = '0; reg2loc = 1'b0; reg_write = 1'b0;
        out_ready = 1'b1; retire = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_pend", 32'(pend_count), 32'd0);
        check("rst_selects", 32'({rs1, rs2, rd, rd_we}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("rst_in_ready", 32'(in_ready), 32'd1);

        // ADD X3,X1,X2 then dependent SUB X4,X3,X5 stalls until retire
        cycle(1, 32'h8B020023, 0, 1, 1, 0);
        repeat (3) cycle(1, {SUBOP, 5'd5, 6'd0, 5'd3, 5'd4}, 0, 1, 1, 0);
        cycle(1, {SUBOP, 5'd5, 6'd0, 5'd3, 5'd4}, 0, 1, 1, 1);
        cycle(1, {SUBOP, 5'd5, 6'd0, 5'd3, 5'd4}, 0, 1, 1, 0);
        drain();

        // MOVK X5 then STUR X7,[X2] with reg2loc
        cycle(1, {MOVK, 16'h1234, 5'd5}, 0, 1, 1, 0);
        cycle(1, {STUR, 9'd0, 2'b00, 5'd2, 5'd7}, 1, 0, 1, 0);
        drain();

        // writes to XZR and non-writers never block later readers
        cycle(1, {ADDOP, 5'd1, 6'd0, 5'd2, 5'd31}, 0, 1, 1, 0);
        cycle(1, {ADDOP, 5'd31, 6'd0, 5'd31, 5'd8}, 0, 1, 1, 0);
        cycle(1, {ADDOP, 5'd1, 6'd0, 5'd2, 5'd6}, 0, 0, 1, 0);
        cycle(1, {ADDOP, 5'd6, 6'd0, 5'd6, 5'd9}, 0, 1, 1, 0);
        drain();

        // fill to DEPTH, fifth held, then steady retire+accept so pointers wrap
        for (int k = 0; k < 5; k++)
            cycle(1, {ADDOP, 5'd20, 6'd0, 5'd21, 5'(10 + k)}, 0, 1, 1, 0);
        for (int k = 0; k < 10; k++)
            cycle(1, {ADDOP, 5'd20, 6'd0, 5'd21, 5'(10 + k % 8)}, 0, 1, 1, 1);
        drain();

        // backpressure: outputs hold, in_ready low
        cycle(1, {ADDOP, 5'd1, 6'd0, 5'd2, 5'd12}, 0, 1, 1, 0);
        repeat (3) cycle(1, {ADDOP, 5'd1, 6'd0, 5'd2, 5'd13}, 0, 1, 0, 0);
        cycle(1, {ADDOP, 5'd1, 6'd0, 5'd2, 5'd13}, 0, 1, 1, 0);
        drain();

        rand_cycles(600);

        // asynchronous reset mid-stream
        @(negedge clk);
        in_valid = 1'b1; instr = {ADDOP, 5'd1, 6'd0, 5'd2, 5'd4}; out_ready = 1'b0; retire = 1'b0;
        #3 rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_pend", 32'(pend_count), 32'd0);
        check("midrst_selects", 32'({rs1, rs2, rd, rd_we}), 32'd0);
        pend_q.delete(); exp_q.delete(); m_ov = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1 check("midrst_in_ready", 32'(in_ready), 32'd1);

        rand_cycles(300);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/regsel_pipe.md
Name: regsel_pipe

Overview:
- Pipelined register-select stage for the LEGv8 datapath. Sits between instruction fetch and the register file.
- Extracts read selects rs1/rs2 and write select rd from the instruction word, honouring MOVK and Reg2Loc.
- Registers the selects behind a valid/ready handshake.
- Tracks in-flight destinations in a pending-write scoreboard FIFO and stalls on read-after-write hazards until the producer retires.

Parameters:
- SEL_W, 5, register-select width (2**SEL_W architectural registers).
- DEPTH, 4, max in-flight instructions tracked by the scoreboard (>=1).
- MOVK_OPC, 11'b11110010100, opcode in instr[31:21] that makes rs1 come from instr[4:0].
- ZERO_REG, 31, register that never creates a hazard (XZR).
- HAZARD_EN, 1, 1 = stall on RAW hazard; 0 = pass-through, scoreboard still counts.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  instruction word valid.
- in_ready  out  1  stage can accept this cycle.
- instr  in  32  instruction word.
- reg2loc  in  1  1: rs2 = instr[4:0]; 0: rs2 = instr[20:16].
- reg_write  in  1  instruction writes rd.
- out_valid  out  1  registered selects valid.
- out_ready  in  1  downstream accepts.
- rs1  out  SEL_W  registered read select 1.
- rs2  out  SEL_W  registered read select 2.
- rd  out  SEL_W  registered write select.
- rd_we  out  1  registered reg_write qualified (0 if rd==ZERO_REG).
- retire  in  1  oldest in-flight instruction has completed writeback.
- pend_count  out  $clog2(DEPTH+1)  scoreboard occupancy.
- hazard  out  1  combinational: incoming instr blocked by RAW.

Behaviour:
- Combinational select decode, using the low SEL_W bits of each field:
  - rs1_n = (instr[31:21]==MOVK_OPC) ? instr[4:0] : instr[9:5].
  - rs2_n = reg2loc ? instr[4:0] : instr[20:16].
  - rd_n = instr[4:0].
  - we_n = reg_write && rd_n!=ZERO_REG.
- Scoreboard:
  - Circular FIFO of DEPTH entries {we, rd}, with head/tail pointers and a count.
  - Each accepted instruction pushes one entry, including non-writers (we=0), so retire pops exactly one per instruction.
- Hazard:
  - hazard = HAZARD_EN && in_valid && some valid entry has we=1 and rd equal to rs1_n or rs2_n.
  - A source equal to ZERO_REG never matches.
- Ready: in_ready = (!out_valid || out_ready) && !hazard && (pend_count<DEPTH).
- Accept: when in_valid && in_ready:
  - Next edge loads rs1/rs2/rd/rd_we from the decode and sets out_valid=1.
  - Pushes {we_n, rd_n}.
- Output handshake:
  - out_valid clears after out_valid && out_ready with no new accept.
  - Outputs hold stable while out_valid && !out_ready.
- Retire:
  - Pops the head entry on the next edge.
  - Retire with pend_count==0 is ignored: no underflow, count stays 0.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Hazard is evaluated on pre-edge state, so a retire that clears the blocking entry lets the instruction be accepted the following cycle, not the same cycle.
- Full: pend_count==DEPTH forces in_ready=0 even if a retire is asserted that cycle.
- Pointers wrap modulo DEPTH. DEPTH need not be a power of two.
- Latency: 1 cycle from accept to out_valid.
- Reset, asynchronous, mid-operation included:
  - out_valid=0; rs1=rs2=rd=0; rd_we=0.
  - Pointers=0; pend_count=0; all entry we bits=0.
  - In-flight instructions are discarded.
  - in_ready is 1 after reset release, given pend_count=0.

Test Plan:
- Basic decode: ADD X3,X1,X2 (instr 0x8B020023), reg2loc=0, reg_write=1 -> next cycle rs1=1, rs2=2, rd=3, rd_we=1, out_valid=1, pend_count=1.
- MOVK/Reg2Loc: MOVK X5 (instr[31:21]=MOVK_OPC, rd=5), then STUR with reg2loc=1, rt=7 -> rs1=5 for MOVK; rs2=7 for STUR.
- RAW stall: ADD X3 accepted, then SUB using X3 with no retire -> hazard=1, in_ready=0 for every cycle until retire. Retire pulse -> in_ready=1 next cycle, accept, pend_count back to 1.
- XZR/no-write: writes to X31, or reg_write=0, followed by reads of that register -> no hazard; entries still counted, and pend_count increments per accept.
- Full/wrap: DEPTH=4, five independent instructions with no retire -> fifth held with in_ready=0 at pend_count=4. Simultaneous retire+accept over 10 cycles -> pend_count steady and pointers wrap correctly. Extra retire at empty -> pend_count stays 0.
- Backpressure/reset: out_ready=0 for 3 cycles -> outputs stable, in_ready=0. Assert rst mid-stream -> out_valid=0, pend_count=0 immediately, without waiting for a clock edge.
